usb_redir_tx_buffer: RTL and testbench
======================================

# usb_redir_tx_buffer

Buffers outgoing bytes from the three USB-redirection producers (MFP serial, PSG/YM parallel, MIDI ACIA) on the system clock. For each channel it presents the `*_data_out_available` / `*_data_out` pair that the SPI user-io block polls. It consumes that block's `*_strobe_out` pulses, which originate in the SPI clock domain, and pops one byte per pulse. Without it, a producer writing faster than the IO controller polls would lose bytes.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries per channel; power of two, 2..64.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, do not override.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `push` input 3: per-channel write request, single-cycle; bit 0 = serial, bit 1 = parallel, bit 2 = midi.
- `push_data` input 24: write bytes; channel n uses `[8n+7:8n]`.
- `full` output 3: per-channel FIFO full.
- `strobe_out` input 3: pop requests from user-io, asynchronous to `clk`, level pulse of several SPI clocks.
- `data_out_available` output 3: per-channel not-empty.
- `data_out` output 24: per-channel head byte.
- `overflow` output 3: sticky, set when a push is dropped.
- `overflow_clr` input 3: clears the corresponding `overflow` bit.
- `level` output 3*(AW+1): per-channel occupancy, channel n at `[(AW+1)(n+1)-1:(AW+1)n]`.

## Operation
- Three independent FIFOs. Each has write pointer `wp` and read pointer `rp`, both AW+1 bits. Empty when `wp==rp`. Full when the MSBs differ and the low AW bits are equal. `level = wp-rp`, modulo 2^(AW+1).
- Push is accepted when `push[n]` is high and the channel is not full (after applying any same-cycle pop). An accepted push writes `mem[wp]` and increments `wp`, wrapping naturally.
- Push on a full channel with no same-cycle pop:
  - the byte is dropped;
  - `wp` is unchanged;
  - `overflow[n]` is set.
- `overflow_clr[n]` and a dropped push in the same cycle: set wins.
- Pop synchroniser, per channel:
  - 2-flop synchroniser on `strobe_out[n]`, then a third flop for rising-edge detection;
  - one pop per rising edge, regardless of how long the pulse lasts.
- Pop on an empty channel is ignored. Pointers and flags are unchanged.
- A simultaneous push and pop on a full channel are both accepted; level stays at DEPTH.
- A simultaneous push and pop on an empty channel:
  - the push is accepted;
  - the pop is ignored;
  - level becomes 1.
- `data_out[n]` is registered and equals `mem[rp]`. It is updated only on a pop, or on a push into an empty FIFO. It is therefore stable while user-io shifts the byte out, since user-io raises the strobe only after the data byte completes.
- `data_out_available[n]` is registered `!empty`.
- Reset values:
  - all pointers 0;
  - `full`, `overflow` 0;
  - `data_out_available` 0;
  - `data_out` 8'h00;
  - `level` 0;
  - synchroniser flops 0.
- Memory contents are not reset.
- Reset mid-operation discards all buffered bytes. A strobe edge that is in flight through the synchroniser is discarded.

## Timing
- Push to `data_out_available`:
  - push at edge k into an empty FIFO gives `data_out_available`=1 and `data_out` valid after edge k+1 (1-cycle latency);
  - `full` and `level` also update after edge k+1.
- Strobe to pop: a `strobe_out` rise asynchronous to `clk` pops at the 3rd or 4th `clk` edge after the rise. `data_out` and `data_out_available` show the next byte after that edge.
- Minimum strobe high and low times are each 2 `clk` periods. User-io pulses last at least 2 SPI clocks, and `clk` is at least 4× the SPI clock.
- Throughput: one push per channel per cycle.

## Structure
- Package `redir_pkg`:
  - channel index constants `CH_SERIAL=0`, `CH_PARALLEL=1`, `CH_MIDI=2`;
  - `NUM_CH=3`;
  - `DEFAULT_DEPTH=8`.
- Sub-module `redir_fifo`: single-channel FIFO with push, pop, head register, full, empty, level and overflow. It is instantiated `NUM_CH` times by a generate loop.
- The strobe synchroniser and edge detector live in the top level.

## Test plan
- Reset, then push 0x41,0x42,0x43 on serial → `data_out_available[0]`=1, `data_out[7:0]`=0x41, `level`=3. Three strobe pulses yield 0x42, 0x43, then available=0.
- Push 9 bytes 0x00..0x08 on midi with DEPTH=8 → `full[2]`=1 and `overflow[2]`=1. Popped sequence is 0x00..0x07. `overflow_clr[2]` clears the flag.
- With parallel full, push 0x55 in the same cycle as a synchronised pop edge → both accepted, level stays 8, and the last popped byte is 0x55.
- A strobe held high for 20 `clk` cycles → exactly one pop. A strobe on an empty channel → no pointer change, and `data_out` stays at its last value.
- Interleaved pushes and strobes on all three channels with random `clk`/SPI phase → per-channel order preserved and no cross-channel interference.
- Assert `reset` with 5 bytes queued and a strobe mid-synchroniser → after release, all outputs are at reset values and no spurious pop occurs.

Source files
------------

// File: rtl/redir_pkg.sv
// Shared constants for the USB-redirection transmit buffer.
package redir_pkg;

   localparam int unsigned NUM_CH        = 3;
   localparam int unsigned DEFAULT_DEPTH = 8;

   localparam int unsigned CH_SERIAL   = 0;
   localparam int unsigned CH_PARALLEL = 1;
   localparam int unsigned CH_MIDI     = 2;

endpackage

// File: rtl/redir_fifo.sv
// Single-channel byte FIFO with registered head byte, flags, level and sticky overflow.
module redir_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   input  logic          overflow_clr,
   output logic          full,
   output logic          data_out_available,
   output logic [7:0]    data_out,
   output logic          overflow,
   output logic [AW:0]   level
);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;
   logic [AW:0] wp_nxt;
   logic [AW:0] rp_nxt;
   logic        empty_c;
   logic        full_c;
   logic        pop_ok;
   logic        push_ok;
   logic        drop;
   logic [7:0]  head_nxt;

   // Accept/drop decisions, next pointers and next head byte
   always_comb begin
      empty_c  = (wp == rp);
      full_c   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
      pop_ok   = pop && !empty_c;
      push_ok  = push && (!full_c || pop_ok);
      drop     = push && !push_ok;
      wp_nxt   = wp + (AW+1)'(push_ok);
      rp_nxt   = rp + (AW+1)'(pop_ok);
      head_nxt = data_out;
      if (empty_c && push_ok) begin
         head_nxt = push_data;
      end else if (pop_ok) begin
         // Popping the only stored byte: new head is the same-cycle push, else hold
         if (rp_nxt == wp) begin
            if (push_ok) head_nxt = push_data;
         end else begin
            head_nxt = mem[rp_nxt[AW-1:0]];
         end
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (push_ok) mem[wp[AW-1:0]] <= push_data;
   end

   // Pointers, registered flags, head byte and sticky overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp                 <= '0;
         rp                 <= '0;
         full               <= 1'b0;
         data_out_available <= 1'b0;
         data_out           <= 8'h00;
         overflow           <= 1'b0;
         level              <= '0;
      end else begin
         wp                 <= wp_nxt;
         rp                 <= rp_nxt;
         full               <= (wp_nxt[AW] != rp_nxt[AW]) && (wp_nxt[AW-1:0] == rp_nxt[AW-1:0]);
         data_out_available <= (wp_nxt != rp_nxt);
         data_out           <= head_nxt;
         level              <= wp_nxt - rp_nxt;
         if (drop)              overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/usb_redir_tx_buffer.sv
// Three-channel transmit buffer between redirection producers and the SPI user-io poller.
module usb_redir_tx_buffer
   import redir_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [2:0]                push,
   input  logic [23:0]               push_data,
   output logic [2:0]                full,
   input  logic [2:0]                strobe_out,
   output logic [2:0]                data_out_available,
   output logic [23:0]               data_out,
   output logic [2:0]                overflow,
   input  logic [2:0]                overflow_clr,
   output logic [3*(AW+1)-1:0]       level
);

   logic [NUM_CH-1:0] strobe_s1;
   logic [NUM_CH-1:0] strobe_s2;
   logic [NUM_CH-1:0] strobe_s3;
   logic [NUM_CH-1:0] pop_c;

   // Two-flop synchroniser plus edge-detect flop on the SPI-domain strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         strobe_s1 <= '0;
         strobe_s2 <= '0;
         strobe_s3 <= '0;
      end else begin
         strobe_s1 <= strobe_out;
         strobe_s2 <= strobe_s1;
         strobe_s3 <= strobe_s2;
      end
   end

   // One pop per synchronised rising edge
   always_comb begin
      pop_c = strobe_s2 & ~strobe_s3;
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      redir_fifo #(
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_fifo (
         .clk                (clk),
         .reset              (reset),
         .push               (push[ch]),
         .push_data          (push_data[8*ch +: 8]),
         .pop                (pop_c[ch]),
         .overflow_clr       (overflow_clr[ch]),
         .full               (full[ch]),
         .data_out_available (data_out_available[ch]),
         .data_out           (data_out[8*ch +: 8]),
         .overflow           (overflow[ch]),
         .level              (level[(AW+1)*ch +: (AW+1)])
      );
   end

endmodule

// File: tb/tb_usb_redir_tx_buffer.sv
// Directed and randomised checks of the three-channel redirection transmit buffer.
module tb_usb_redir_tx_buffer;
   import redir_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 3;
   localparam int unsigned LW    = AW + 1;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [2:0]      push = '0;
   logic [23:0]     push_data = '0;
   logic [2:0]      full;
   logic [2:0]      strobe_out = '0;
   logic [2:0]      data_out_available;
   logic [23:0]     data_out;
   logic [2:0]      overflow;
   logic [2:0]      overflow_clr = '0;
   logic [3*LW-1:0] level;

   int total = 0;
   int bad   = 0;

   logic [7:0] q    [NUM_CH][$];
   logic [7:0] head [NUM_CH];
   logic       ovf  [NUM_CH];

   usb_redir_tx_buffer #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .reset              (reset),
      .push               (push),
      .push_data          (push_data),
      .full               (full),
      .strobe_out         (strobe_out),
      .data_out_available (data_out_available),
      .data_out           (data_out),
      .overflow           (overflow),
      .overflow_clr       (overflow_clr),
      .level              (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_ch(input int ch, input string tag);
      check($sformatf("%s.avail%0d", tag, ch), 32'(data_out_available[ch]), 32'(q[ch].size() != 0));
      check($sformatf("%s.data%0d", tag, ch), 32'(data_out[8*ch +: 8]), 32'(head[ch]));
      check($sformatf("%s.level%0d", tag, ch), 32'(level[LW*ch +: LW]), 32'(q[ch].size()));
      check($sformatf("%s.full%0d", tag, ch), 32'(full[ch]), 32'(q[ch].size() == DEPTH));
      check($sformatf("%s.ovf%0d", tag, ch), 32'(overflow[ch]), 32'(ovf[ch]));
   endtask

   task automatic check_all(input string tag);
      for (int ch = 0; ch < NUM_CH; ch++) check_ch(ch, tag);
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         q[ch].delete();
         head[ch] = 8'h00;
         ovf[ch]  = 1'b0;
      end
   endtask

   task automatic model_push(input int ch, input logic [7:0] b);
      if (q[ch].size() < DEPTH) begin
         if (q[ch].size() == 0) head[ch] = b;
         q[ch].push_back(b);
      end else begin
         ovf[ch] = 1'b1;
      end
   endtask

   task automatic model_pop(input int ch);
      if (q[ch].size() > 0) begin
         void'(q[ch].pop_front());
         if (q[ch].size() > 0) head[ch] = q[ch][0];
      end
   endtask

   // One-cycle push of the selected channels, driven at the falling edge
   task automatic do_push(input logic [2:0] mask, input logic [23:0] d);
      @(negedge clk);
      push      = mask;
      push_data = d;
      for (int ch = 0; ch < NUM_CH; ch++)
         if (mask[ch]) model_push(ch, d[8*ch +: 8]);
      @(negedge clk);
      push = '0;
   endtask

   // Strobe aligned to the falling edge, held for hold_cyc cycles, then settled
   task automatic do_strobe(input int ch, input int hold_cyc);
      @(negedge clk);
      strobe_out[ch] = 1'b1;
      repeat (hold_cyc) @(negedge clk);
      strobe_out[ch] = 1'b0;
      repeat (4) @(negedge clk);
      model_pop(ch);
   endtask

   // Strobe at an arbitrary phase relative to clk
   task automatic async_strobe(input int ch);
      @(posedge clk);
      #($urandom_range(1, 9));
      strobe_out[ch] = 1'b1;
      #($urandom_range(25, 45));
      strobe_out[ch] = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      model_pop(ch);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_all("reset");

      // Basic serial order
      do_push(3'b001, 24'h000041);
      do_push(3'b001, 24'h000042);
      do_push(3'b001, 24'h000043);
      check_all("ser_push");
      do_strobe(CH_SERIAL, 3);
      check_all("ser_pop1");
      do_strobe(CH_SERIAL, 3);
      check_all("ser_pop2");
      do_strobe(CH_SERIAL, 3);
      check_all("ser_pop3");

      // MIDI overflow
      for (int i = 0; i < 9; i++) do_push(3'b100, {8'(i), 16'h0000});
      check_all("midi_full");
      @(negedge clk);
      overflow_clr = 3'b100;
      ovf[CH_MIDI] = 1'b0;
      @(negedge clk);
      overflow_clr = '0;
      check_all("midi_clr");
      for (int i = 0; i < 8; i++) begin
         do_strobe(CH_MIDI, 2);
         check_all($sformatf("midi_pop%0d", i));
      end

      // Parallel full with push coincident with the pop edge
      for (int i = 0; i < 8; i++) do_push(3'b010, {8'h00, 8'(8'hA0 + i), 8'h00});
      check_all("par_full");
      @(negedge clk);
      strobe_out[CH_PARALLEL] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      push      = 3'b010;
      push_data = 24'h005500;
      model_pop(CH_PARALLEL);
      model_push(CH_PARALLEL, 8'h55);
      @(negedge clk);
      push = '0;
      check_all("par_pushpop");
      strobe_out[CH_PARALLEL] = 1'b0;
      repeat (4) @(negedge clk);
      check_all("par_settle");
      for (int i = 0; i < 8; i++) begin
         do_strobe(CH_PARALLEL, 2);
         check_all($sformatf("par_pop%0d", i));
      end
      check("par_last", 32'(data_out[15:8]), 32'h55);

      // Long strobe gives one pop; strobe on empty changes nothing
      do_push(3'b001, 24'h000010);
      do_push(3'b001, 24'h000011);
      do_strobe(CH_SERIAL, 20);
      check_all("long_strobe");
      do_strobe(CH_SERIAL, 2);
      check_all("drain");
      do_strobe(CH_SERIAL, 2);
      check_all("empty_strobe");
      check("empty_hold", 32'(data_out[7:0]), 32'h11);

      // Random interleave at random strobe phase
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            do_push(3'($urandom_range(1, 7)), 24'($urandom));
         end else begin
            async_strobe(int'($urandom_range(0, 2)));
         end
         check_all($sformatf("rnd%0d", it));
      end

      // Reset mid-operation with a strobe inside the synchroniser
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) do_push(3'b001, {16'h0000, 8'(8'hC0 + i)});
      check_all("pre_reset");
      @(negedge clk);
      strobe_out[CH_SERIAL] = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
      strobe_out[CH_SERIAL] = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      check_all("post_reset");
      do_push(3'b001, 24'h0000E7);
      repeat (6) @(negedge clk);
      check_all("no_spurious_pop");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
